// File: rtl/l1_dcache_pkg.sv
// rtl/l1_dcache_pkg.sv - shared cache types: FSM state, line type, line width
package cache_types;
    localparam int CACHE_LINE_BITS = 256;

    typedef logic [CACHE_LINE_BITS-1:0] cache_line_t;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;
endpackage

// File: rtl/l1_dcache_if.sv
// rtl/l1_dcache_if.sv - CPU word port and memory line port bundle
interface l1_dcache_if;
    import cache_types::*;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_addr;
    cache_line_t pmem_wdata;
    cache_line_t pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_wmask, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, mem_wmask, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/l1_dcache_array.sv
// rtl/l1_dcache_array.sv - per-set valid/dirty/tag/line flops, async read, byte-masked write
module l1_dcache_array
    import cache_types::*;
#(
    parameter int S_INDEX = 3,
    parameter int TAG_W   = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [S_INDEX-1:0]           idx_i,
    output logic                         valid_o,
    output logic                         dirty_o,
    output logic [TAG_W-1:0]             tag_o,
    output cache_line_t                  line_o,
    input  logic [CACHE_LINE_BITS/8-1:0] line_we_i,
    input  cache_line_t                  line_wdata_i,
    input  logic                         tag_we_i,
    input  logic [TAG_W-1:0]             tag_wdata_i,
    input  logic                         valid_set_i,
    input  logic                         dirty_set_i,
    input  logic                         dirty_clr_i
);
    localparam int SETS  = 1 << S_INDEX;
    localparam int BYTES = CACHE_LINE_BITS / 8;

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    cache_line_t      data_q [SETS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (valid_set_i) valid_q[idx_i] <= 1'b1;
            if (dirty_set_i)      dirty_q[idx_i] <= 1'b1;
            else if (dirty_clr_i) dirty_q[idx_i] <= 1'b0;
        end
    end

    // Tag and data need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (tag_we_i) tag_q[idx_i] <= tag_wdata_i;
        for (int b = 0; b < BYTES; b++) begin
            if (line_we_i[b]) data_q[idx_i][8*b +: 8] <= line_wdata_i[8*b +: 8];
        end
    end
endmodule

// File: rtl/l1_dcache.sv
// rtl/l1_dcache.sv - direct-mapped write-back write-allocate L1 D-cache
// Optional hit/miss counters under `DCACHE_PERF_EN.
module l1_dcache
    import cache_types::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    l1_dcache_if.slave  bus
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int TAG_W  = 32 - S_OFFSET - S_INDEX;
    localparam int WORD_W = S_OFFSET - 2;
    localparam int BYTES  = CACHE_LINE_BITS / 8;

    cache_state_t state_q, state_d;

    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] idx;
    logic [WORD_W-1:0]  word;
    logic               req;
    logic               hit;
    logic               unused_addr_lsb;

    logic               arr_valid, arr_dirty;
    logic [TAG_W-1:0]   arr_tag;
    cache_line_t        arr_line;
    logic [BYTES-1:0]   line_we;
    cache_line_t        line_wdata;
    logic               tag_we, valid_set, dirty_set, dirty_clr;
    logic               miss_start, hit_done;
    logic [BYTES-1:0]   hit_mask;
    logic [31:0]        rd_word;

    assign req_tag         = bus.mem_addr[31 -: TAG_W];
    assign idx             = bus.mem_addr[S_OFFSET +: S_INDEX];
    assign word            = bus.mem_addr[2 +: WORD_W];
    assign unused_addr_lsb = ^bus.mem_addr[1:0];
    assign req             = bus.mem_read | bus.mem_write;
    assign hit             = arr_valid && (arr_tag == req_tag);
    assign hit_mask        = {{(BYTES-4){1'b0}}, bus.mem_wmask} << (4 * word);
    assign rd_word         = arr_line[32*word +: 32];

    l1_dcache_array #(
        .S_INDEX (S_INDEX),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .idx_i        (idx),
        .valid_o      (arr_valid),
        .dirty_o      (arr_dirty),
        .tag_o        (arr_tag),
        .line_o       (arr_line),
        .line_we_i    (line_we),
        .line_wdata_i (line_wdata),
        .tag_we_i     (tag_we),
        .tag_wdata_i  (req_tag),
        .valid_set_i  (valid_set),
        .dirty_set_i  (dirty_set),
        .dirty_clr_i  (dirty_clr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= COMPARE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.mem_resp    = 1'b0;
        bus.mem_rdata   = '0;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        bus.pmem_addr   = '0;
        bus.pmem_wdata  = '0;
        line_we         = '0;
        line_wdata      = {(CACHE_LINE_BITS/32){bus.mem_wdata}};
        tag_we          = 1'b0;
        valid_set       = 1'b0;
        dirty_set       = 1'b0;
        dirty_clr       = 1'b0;
        miss_start      = 1'b0;
        hit_done        = 1'b0;
        unique case (state_q)
            COMPARE: begin
                if (req) begin
                    if (hit) begin
                        bus.mem_resp = 1'b1;
                        hit_done     = 1'b1;
                        // Write wins when both strobes are (illegally) high.
                        if (bus.mem_write) begin
                            line_we   = hit_mask;
                            dirty_set = 1'b1;
                        end else begin
                            bus.mem_rdata = rd_word;
                        end
                    end else begin
                        miss_start = 1'b1;
                        state_d    = (arr_valid && arr_dirty) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.pmem_addr  = {arr_tag, idx, {S_OFFSET{1'b0}}};
                bus.pmem_wdata = arr_line;
                if (bus.pmem_resp) begin
                    dirty_clr = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                bus.pmem_addr = {req_tag, idx, {S_OFFSET{1'b0}}};
                if (bus.pmem_resp) begin
                    line_we    = '1;
                    line_wdata = bus.pmem_rdata;
                    tag_we     = 1'b1;
                    valid_set  = 1'b1;
                    dirty_clr  = 1'b1;
                    state_d    = COMPARE;
                end
            end
            default: state_d = COMPARE;
        endcase
    end

`ifdef DCACHE_PERF_EN
    logic miss_pend_q;

    // The hit that closes a miss belongs to that miss, not to the hit count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count   <= '0;
            miss_count  <= '0;
            miss_pend_q <= 1'b0;
        end else begin
            if (miss_start) begin
                miss_count  <= miss_count + 32'd1;
                miss_pend_q <= 1'b1;
            end
            if (hit_done) begin
                if (!miss_pend_q) hit_count <= hit_count + 32'd1;
                miss_pend_q <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.mem_read && bus.mem_write))
                else $error("l1_dcache: mem_read and mem_write both asserted");
            assert (!(bus.pmem_read && bus.pmem_write))
                else $error("l1_dcache: pmem_read and pmem_write both asserted");
        end
    end
endmodule

// File: tb/tb_l1_dcache.sv
// tb/tb_l1_dcache.sv - directed self-checking bench for l1_dcache
module tb_l1_dcache;
    import cache_types::*;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        cache_line_t data;
    } pmem_rec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   fill_delay;
    int   wb_delay;
    pmem_rec_t   log_q [$];
    cache_line_t mem_model [logic [31:0]];

    l1_dcache_if bus ();

`ifdef DCACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    l1_dcache dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef DCACHE_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic cache_line_t default_line(input logic [31:0] a);
        cache_line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = a + 32'(i) * 32'h0100_0000;
        return l;
    endfunction

    function automatic cache_line_t model_line(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return default_line(a);
    endfunction

    // Memory responder: pmem_resp in the Nth cycle of a held request.
    initial begin
        int cnt;
        cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read || bus.pmem_write) begin
                cnt++;
                if (cnt >= (bus.pmem_write ? wb_delay : fill_delay)) begin
                    cnt = 0;
                    if (bus.pmem_write) begin
                        mem_model[bus.pmem_addr] = bus.pmem_wdata;
                        log_q.push_back('{1'b1, bus.pmem_addr, bus.pmem_wdata});
                    end else begin
                        bus.pmem_rdata = model_line(bus.pmem_addr);
                        log_q.push_back('{1'b0, bus.pmem_addr, bus.pmem_rdata});
                    end
                    bus.pmem_resp = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic cpu_op(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input int exp_lat, input logic [31:0] exp_rdata);
        int          lat;
        logic [31:0] rdata;
        lat   = 0;
        rdata = '0;
        bus.mem_read  = ~wr;
        bus.mem_write = wr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wmask = wmask;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                lat   = c;
                rdata = bus.mem_rdata;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_lat"}, 256'(lat), 256'(exp_lat));
        if (!wr) check({tag, "_rdata"}, 256'(rdata), 256'(exp_rdata));
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        cache_line_t l40, l140, exp_wb;
        int          base;
        int          seen;

        checks     = 0;
        failures   = 0;
        fill_delay = 3;
        wb_delay   = 2;

        l40 = default_line(32'h40);
        l40[31:0]  = 32'hDEAD_BEEF;
        l40[63:32] = 32'h1122_3344;
        mem_model[32'h40] = l40;
        l140 = default_line(32'h140);
        l140[31:0] = 32'hCAFE_0140;
        mem_model[32'h140] = l140;
        exp_wb = l40;
        exp_wb[63:32] = 32'h1122_AB44;

        rst_n         = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_resp",   256'(bus.mem_resp),   256'(0));
        check("rst_pmem_read",  256'(bus.pmem_read),  256'(0));
        check("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
        check("rst_pmem_addr",  256'(bus.pmem_addr),  256'(0));
        check("rst_mem_rdata",  256'(bus.mem_rdata),  256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cold read: miss + 3-cycle fill + compare hit.
        base = log_q.size();
        cpu_op("cold_rd", 1'b0, 32'h40, '0, '0, 5, 32'hDEAD_BEEF);
        check("cold_nxfer", 256'(log_q.size() - base), 256'(1));
        check("cold_wr",    256'(log_q[base].wr),       256'(0));
        check("cold_addr",  256'(log_q[base].addr),     256'(32'h40));

        cpu_op("wr_hit", 1'b1, 32'h44, 32'h0000_AB00, 4'b0010, 1, '0);
        cpu_op("rd_after_wr", 1'b0, 32'h44, '0, '0, 1, 32'h1122_AB44);

        // Dirty conflict miss: writeback 0x40 (2 cycles), fill 0x140 (1 cycle).
        fill_delay = 1;
        base = log_q.size();
        cpu_op("dirty_ev", 1'b0, 32'h140, '0, '0, 5, 32'hCAFE_0140);
        check("dirty_nxfer", 256'(log_q.size() - base), 256'(2));
        check("dirty_wb_op",   256'(log_q[base].wr),     256'(1));
        check("dirty_wb_addr", 256'(log_q[base].addr),   256'(32'h40));
        check("dirty_wb_data", log_q[base].data,         exp_wb);
        check("dirty_rd_op",   256'(log_q[base+1].wr),   256'(0));
        check("dirty_rd_addr", 256'(log_q[base+1].addr), 256'(32'h140));

        // Clean conflict miss: only a fill; written-back data comes back.
        fill_delay = 2;
        base = log_q.size();
        cpu_op("clean_ev", 1'b0, 32'h44, '0, '0, 4, 32'h1122_AB44);
        check("clean_nxfer", 256'(log_q.size() - base), 256'(1));
        check("clean_op",    256'(log_q[base].wr),       256'(0));
        check("clean_addr",  256'(log_q[base].addr),     256'(32'h40));

        // Reset while a fill is outstanding.
        fill_delay = 50;
        bus.mem_read = 1'b1;
        bus.mem_addr = 32'h240;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.pmem_read) begin
                seen = 1;
                break;
            end
        end
        check("midfill_pmem_read", 256'(seen), 256'(1));
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_pmem_read",  256'(bus.pmem_read),  256'(0));
        check("midrst_pmem_write", 256'(bus.pmem_write), 256'(0));
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        fill_delay = 3;

        base = log_q.size();
        cpu_op("reread", 1'b0, 32'h40, '0, '0, 5, 32'hDEAD_BEEF);
        check("reread_nxfer", 256'(log_q.size() - base), 256'(1));
        check("reread_addr",  256'(log_q[base].addr),     256'(32'h40));

        cpu_op("hit_rd44", 1'b0, 32'h44, '0, '0, 1, 32'h1122_AB44);
        cpu_op("hit_wr48", 1'b1, 32'h48, 32'h5555_AAAA, 4'b1111, 1, '0);
        cpu_op("hit_rd48", 1'b0, 32'h48, '0, '0, 1, 32'h5555_AAAA);
        fill_delay = 1;
        cpu_op("miss_60", 1'b0, 32'h60, '0, '0, 3, 32'h0000_0060);

`ifdef DCACHE_PERF_EN
        check("perf_miss", 256'(miss_count), 256'(2));
        check("perf_hit",  256'(hit_count),  256'(3));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
